key_arbiter: RTL and testbench

KEY_ARBITER -- requirements
Module: key_arbiter

---
 rtl/key_arb_pkg.sv | 12 +
 rtl/sync_chain.sv | 30 +++
 rtl/key_arbiter.sv | 131 +++++++++++++
 tb/tb_key_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_arb_pkg.sv
// Shared types and default parameters for the key arbiter.
package key_arb_pkg;

  localparam int unsigned KEY_ARB_N_DEFAULT    = 4;
  localparam int unsigned KEY_ARB_SYNC_DEFAULT = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/sync_chain.sv
// Single-bit synchronizer: STAGES-deep flop chain with async active-low reset.
module sync_chain
  import key_arb_pkg::*;
#(
  parameter int unsigned STAGES = KEY_ARB_SYNC_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/key_arbiter.sv
// Round-robin arbiter for N asynchronous key requesters: synchronize, detect
// rises, latch pending requests and offer them one at a time to a shared resource.
module key_arbiter
  import key_arb_pkg::*;
#(
  parameter int unsigned N           = KEY_ARB_N_DEFAULT,
  parameter int unsigned SYNC_STAGES = KEY_ARB_SYNC_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] keys_async,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  input  logic         grant_ready,
  output logic [N-1:0] pending,
  output logic         overflow
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);

  logic [N-1:0]  key_sync;
  logic [N-1:0]  prev_q, prev_d;
  logic [N-1:0]  rise;
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  clr;
  logic          grant_valid_q, grant_valid_d;
  logic          overflow_q, overflow_d;
  logic          transfer;
  logic [IW-1:0] last_q, last_d;
  arb_state_e    state_q, state_d;

  for (genvar i = 0; i < N; i++) begin : g_sync
    sync_chain #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (keys_async[i]),
      .q    (key_sync[i])
    );
  end

  // First set bit of req, searching upward from (last+1) mod N with wrap.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req,
                                           input logic [IW-1:0] last);
    logic [N-1:0]  pick;
    logic          found;
    logic [IW-1:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IW'((32'(last) + k) % N);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IW-1:0] onehot_idx(input logic [N-1:0] oh);
    logic [IW-1:0] idx;
    idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (oh[k]) idx = IW'(k);
    end
    return idx;
  endfunction

  // A rise coinciding with its own clear re-arms the request without overflow.
  always_comb begin
    prev_d     = key_sync;
    rise       = key_sync & ~prev_q;
    transfer   = (state_q == OFFER) && grant_valid_q && grant_ready;
    clr        = transfer ? grant_q : '0;
    pending_d  = (pending_q & ~clr) | rise;
    overflow_d = |(rise & pending_q & ~clr);
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    last_d        = last_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_d       = rr_pick(pending_q, last_q);
          grant_valid_d = 1'b1;
          state_d       = OFFER;
        end
      end
      OFFER: begin
        if (transfer) begin
          last_d        = onehot_idx(grant_q);
          grant_d       = '0;
          grant_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q        <= '0;
      pending_q     <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      last_q        <= LAST_RST;
      state_q       <= IDLE;
    end else begin
      prev_q        <= prev_d;
      pending_q     <= pending_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      overflow_q    <= overflow_d;
      last_q        <= last_d;
      state_q       <= state_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign pending     = pending_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_key_arbiter.sv
// Scoreboard bench for key_arbiter: stimulus queues expected grants, a monitor
// pops and compares them on every transfer.
module tb_key_arbiter;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] keys_async;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic         grant_ready;
  logic [N-1:0] pending;
  logic         overflow;

  int unsigned  passes = 0;
  int unsigned  total  = 0;
  int unsigned  cyc    = 0;
  int unsigned  ovf_cnt;
  logic [N-1:0] exp_q[$];
  int unsigned  xfer_q[$];
  logic [N-1:0] mon_exp;

  key_arbiter #(
    .N          (N),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .keys_async (keys_async),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_ready(grant_ready),
    .pending    (pending),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && grant_valid === 1'b1 && grant_ready === 1'b1) begin
      xfer_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_transfer: got grant %b expected no transfer", grant);
      end else begin
        mon_exp = exp_q.pop_front();
        check("transfer_grant", 32'(grant), 32'(mon_exp));
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int unsigned budget);
    int unsigned k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    total++;
    if (exp_q.size() == 0) passes++;
    else begin
      $display("FAIL %s: got %0d grants outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_valid(input string name, input int unsigned budget);
    int unsigned k = 0;
    while (grant_valid !== 1'b1 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    total++;
    if (grant_valid === 1'b1) passes++;
    else $display("FAIL %s: got grant_valid %b expected 1 within %0d cycles", name, grant_valid, budget);
  endtask

  initial begin
    reset       = 1'b0;
    keys_async  = '0;
    grant_ready = 1'b0;
    #2;
    check("rst_grant", 32'(grant), 0);
    check("rst_valid", 32'(grant_valid), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_overflow", 32'(overflow), 0);
    tick(2);
    reset = 1'b1;

    // Single key 2: pending two edges after capture, offer one edge later.
    grant_ready = 1'b1;
    keys_async  = 4'b0100;
    exp_q.push_back(4'b0100);
    @(posedge clk);
    @(posedge clk); @(negedge clk);
    check("a_pending_early", 32'(pending), 0);
    @(posedge clk); @(negedge clk);
    check("a_pending_set", 32'(pending), 32'b0100);
    check("a_valid_low", 32'(grant_valid), 0);
    @(posedge clk); @(negedge clk);
    check("a_grant", 32'(grant), 32'b0100);
    check("a_valid_high", 32'(grant_valid), 1);
    @(posedge clk); @(negedge clk);
    check("a_pending_clr", 32'(pending), 0);
    check("a_grant_clr", 32'(grant), 0);
    check("a_valid_clr", 32'(grant_valid), 0);
    wait_drain("a_drain", 5);
    keys_async = '0;
    tick(4);

    // All four keys together after reset: rotation 0,1,2,3 every 2 cycles.
    reset = 1'b0;
    tick(2);
    reset      = 1'b1;
    keys_async = 4'b1111;
    xfer_q.delete();
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    wait_drain("b_drain", 40);
    check("b_xfer_count", xfer_q.size(), 4);
    if (xfer_q.size() == 4) begin
      for (int i = 0; i < 3; i++) check("b_spacing", xfer_q[i+1] - xfer_q[i], 2);
    end
    keys_async = '0;
    tick(4);

    // Back-pressure: offer held stable for 10 cycles, transfer when ready.
    grant_ready = 1'b0;
    keys_async  = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_valid("c_offer", 10);
    repeat (10) begin
      @(negedge clk);
      check("c_hold", {27'd0, grant_valid, grant}, 32'b10001);
    end
    @(posedge clk); #1;
    grant_ready = 1'b1;
    wait_drain("c_drain", 5);
    keys_async = '0;
    tick(4);

    // Second rise on key 1 while it waits behind key 3: overflow, one grant.
    grant_ready = 1'b0;
    keys_async  = 4'b1000;
    tick(5);
    keys_async = 4'b1010;
    tick(5);
    keys_async = 4'b1000;
    tick(3);
    keys_async = 4'b1010;
    ovf_cnt    = 0;
    repeat (6) begin
      @(negedge clk);
      ovf_cnt += 32'(overflow);
    end
    check("d_overflow_count", ovf_cnt, 1);
    check("d_pending", 32'(pending), 32'b1010);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010);
    @(posedge clk); #1;
    grant_ready = 1'b1;
    keys_async  = '0;
    wait_drain("d_drain", 20);
    tick(6);

    // Key 3 re-rises in the very cycle its grant transfers.
    grant_ready = 1'b0;
    keys_async  = 4'b1011;
    tick(6);
    check("e_offer3", 32'(grant), 32'b1000);
    keys_async = 4'b0011;
    tick(4);
    keys_async = 4'b1011;
    @(posedge clk);
    @(posedge clk); #1;
    grant_ready = 1'b1;
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    @(posedge clk); @(negedge clk);
    check("e_no_overflow", 32'(overflow), 0);
    check("e_pending", 32'(pending), 32'b1011);
    @(posedge clk); @(negedge clk);
    check("e_no_overflow_late", 32'(overflow), 0);
    wait_drain("e_drain", 20);
    keys_async = '0;
    tick(6);

    // Reset mid-offer abandons it; held keys re-register once after release.
    grant_ready = 1'b0;
    keys_async  = 4'b0110;
    tick(6);
    check("f_offer", 32'(grant_valid), 1);
    check("f_pending", 32'(pending), 32'b0110);
    #3;
    reset = 1'b0;
    #1;
    check("f_rst_grant", 32'(grant), 0);
    check("f_rst_valid", 32'(grant_valid), 0);
    check("f_rst_pending", 32'(pending), 0);
    check("f_rst_overflow", 32'(overflow), 0);
    tick(2);
    reset       = 1'b1;
    grant_ready = 1'b1;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    @(negedge clk);
    check("f_idle_after_release", 32'(grant_valid), 0);
    wait_drain("f_drain", 30);
    tick(6);
    keys_async = '0;
    tick(2);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
